// File: rtl/rca_pipe.sv
// -----------------------------------------------------------------------------
// rca_pipe -- pipelined segmented ripple-carry adder/subtractor.
//
// A WIDTH-bit add (or subtract) is split into NSTG = WIDTH/SEG segments of
// SEG bits each. One segment is resolved per pipeline stage, and the carry is
// registered between stages. The pipe uses a valid/ready handshake. A single
// global advance signal either moves every stage forward or freezes the whole
// pipe.
//
// Latency from the accepting clock edge to out_valid is NSTG edges. Stage 0's
// segment is added combinationally from the input ports into the first
// register bank. The last register bank is also the output register.
//
// Parameters:
//   WIDTH  operand/sum width (must be a multiple of SEG), default 32
//   SEG    bits resolved per stage, default 4
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   beat accepted when in_valid & in_ready
//   a, b       operands
//   ci         carry-in (ignored when sub=1)
//   sub        1: compute a - b (b inverted, carry-in forced to 1)
//   out_valid  result valid
//   out_ready  result consumed when out_valid & out_ready
//   s          sum / difference
//   co         carry-out of the MSB (for subtraction, 1 = no borrow)
//   ovf        signed overflow; present only when RCA_PIPE_OVF_EN is defined
//
// Optional feature macro: RCA_PIPE_OVF_EN
//   When defined, this adds the registered output ovf (reset value 0). ovf is
//   the XOR of the carry into the MSB and the carry out of the MSB.
// -----------------------------------------------------------------------------
module rca_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSTG = WIDTH / SEG;
  // Operand registers exist only between stages. When NSTG=1 there are none,
  // so the arrays are sized to a minimum of one unused element.
  localparam int OPN  = (NSTG > 1) ? NSTG - 1 : 1;
  localparam int OPW  = (NSTG > 1) ? WIDTH - SEG : 1;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Per-stage inputs, wired up in the generate loop below.
  logic [WIDTH-1:0] op_in_a [NSTG];  // operand A with this stage's segment at bit 0
  logic [WIDTH-1:0] op_in_b [NSTG];
  logic             cin_in  [NSTG];
  logic             v_in    [NSTG];
  logic [WIDTH-1:0] res_in  [NSTG];  // result bits already resolved upstream

  logic [SEG:0]     seg_sum [NSTG];

  logic             v_d   [NSTG];
  logic             v_q   [NSTG];
  logic [WIDTH-1:0] res_d [NSTG];
  logic [WIDTH-1:0] res_q [NSTG];
  logic             c_d   [NSTG];
  logic             c_q   [NSTG];
  logic [OPW-1:0]   opa_d [OPN];
  logic [OPW-1:0]   opa_q [OPN];
  logic [OPW-1:0]   opb_d [OPN];
  logic [OPW-1:0]   opb_q [OPN];

`ifdef RCA_PIPE_OVF_EN
  logic ovf_d;
  logic ovf_q;
`endif

  // The pipe moves as a whole whenever the output slot is empty or is being
  // drained this cycle.
  assign adv      = ~v_q[NSTG-1] | out_ready;
  assign in_ready = adv;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : ci;

  genvar gi;
  generate
    for (gi = 0; gi < NSTG; gi++) begin : g_stg
      if (gi == 0) begin : g_first
        assign op_in_a[gi] = a;
        assign op_in_b[gi] = b_eff;
        assign cin_in[gi]  = c0;
        assign v_in[gi]    = in_valid;
        assign res_in[gi]  = '0;
      end else begin : g_next
        // Bits already consumed were shifted out, so the zero-extended
        // remainder has this stage's segment at bit 0.
        assign op_in_a[gi] = WIDTH'(opa_q[gi-1]);
        assign op_in_b[gi] = WIDTH'(opb_q[gi-1]);
        assign cin_in[gi]  = c_q[gi-1];
        assign v_in[gi]    = v_q[gi-1];
        assign res_in[gi]  = res_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < OPN; k++) begin
      opa_d[k] = '0;
      opb_d[k] = '0;
    end
    for (int k = 0; k < NSTG; k++) begin
      seg_sum[k] = {1'b0, op_in_a[k][SEG-1:0]}
                 + {1'b0, op_in_b[k][SEG-1:0]}
                 + (SEG+1)'(cin_in[k]);
      v_d[k]     = v_in[k];
      res_d[k]   = res_in[k] | (WIDTH'(seg_sum[k][SEG-1:0]) << (k * SEG));
      c_d[k]     = seg_sum[k][SEG];
    end
    // Only the bits above the current segment travel on to later stages.
    for (int k = 0; k < NSTG - 1; k++) begin
      opa_d[k] = OPW'(op_in_a[k] >> SEG);
      opb_d[k] = OPW'(op_in_b[k] >> SEG);
    end
`ifdef RCA_PIPE_OVF_EN
    // At the MSB, sum = a ^ b ^ carry_in, so carry_in = a ^ b ^ sum.
    ovf_d = op_in_a[NSTG-1][SEG-1] ^ op_in_b[NSTG-1][SEG-1]
          ^ seg_sum[NSTG-1][SEG-1] ^ seg_sum[NSTG-1][SEG];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NSTG; k++) begin
        v_q[k]   <= 1'b0;
        res_q[k] <= '0;
        c_q[k]   <= 1'b0;
      end
      for (int k = 0; k < OPN; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
`ifdef RCA_PIPE_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (adv) begin
      // Bubbles shift through with v=0; their data content is don't-care.
      for (int k = 0; k < NSTG; k++) begin
        v_q[k]   <= v_d[k];
        res_q[k] <= res_d[k];
        c_q[k]   <= c_d[k];
      end
      for (int k = 0; k < OPN; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
      end
`ifdef RCA_PIPE_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  // The last stage's register bank is the output register.
  assign out_valid = v_q[NSTG-1];
  assign s         = res_q[NSTG-1];
  assign co        = c_q[NSTG-1];
`ifdef RCA_PIPE_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rca_pipe.sv
// -----------------------------------------------------------------------------
// tb_rca_pipe -- directed, self-checking bench for rca_pipe (WIDTH=32, SEG=4).
// Inputs are driven on the falling clock edge, and outputs are sampled there
// as well. Latency is counted in rising edges from the accepting edge onward.
// -----------------------------------------------------------------------------
module tb_rca_pipe;
  localparam int WIDTH = 32;
  localparam int SEG   = 4;
  localparam int NSTG  = WIDTH / SEG;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
`ifdef RCA_PIPE_OVF_EN
  logic             ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rca_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co)
`ifdef RCA_PIPE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic drive_idle();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    ci       = 1'b0;
    sub      = 1'b0;
  endtask

  // Called at the falling edge after the accepting edge. Returns the number
  // of rising edges, including the accepting edge, until out_valid is seen.
  // The count is capped at 30 edges.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (s !== 32'h0) begin bad++; $display("FAIL reset_s: got %h want 00000000", s); end
    total++; if (co !== 1'b0) begin bad++; $display("FAIL reset_co: got %b want 0", co); end
`ifdef RCA_PIPE_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    reset = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
    $display("reset: out_valid=%b s=%h co=%b in_ready=%b", out_valid, s, co, in_ready);
  endtask

  task automatic test_full_ripple();
    int lat;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    drive_idle();
    wait_out(lat);
    total++; if (lat !== NSTG) begin bad++; $display("FAIL ripple_latency: got %0d want %0d", lat, NSTG); end
    total++; if (s !== 32'h0) begin bad++; $display("FAIL ripple_s: got %h want 00000000", s); end
    total++; if (co !== 1'b1) begin bad++; $display("FAIL ripple_co: got %b want 1", co); end
`ifdef RCA_PIPE_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ripple_ovf: got %b want 0", ovf); end
`endif
    $display("ripple: FFFFFFFF+1 lat=%0d s=%h co=%b", lat, s, co);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ripple_retire: got %b want 0", out_valid); end
  endtask

  task automatic test_sub();
    // The first beat drives ci=1 to confirm that sub forces the carry-in.
    @(negedge clk);
    a = 32'd5; b = 32'd7; ci = 1'b1; sub = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    a = 32'd7; b = 32'd5; ci = 1'b0; sub = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    drive_idle();
    repeat (NSTG - 2) @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sub1_valid: got %b want 1", out_valid); end
    total++; if (s !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub1_s: got %h want fffffffe", s); end
    total++; if (co !== 1'b0) begin bad++; $display("FAIL sub1_co: got %b want 0", co); end
`ifdef RCA_PIPE_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL sub1_ovf: got %b want 0", ovf); end
`endif
    $display("sub: 5-7 s=%h co=%b", s, co);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sub2_valid: got %b want 1", out_valid); end
    total++; if (s !== 32'd2) begin bad++; $display("FAIL sub2_s: got %h want 00000002", s); end
    total++; if (co !== 1'b1) begin bad++; $display("FAIL sub2_co: got %b want 1", co); end
    $display("sub: 7-5 s=%h co=%b", s, co);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sub_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int got   = 0;
    int first = -1;
    int last  = -1;
    logic [WIDTH-1:0] exp_s;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        exp_s = WIDTH'(3 * got + (got & 1));
        total++; if (s !== exp_s) begin bad++; $display("FAIL b2b_s[%0d]: got %h want %h", got, s, exp_s); end
        total++; if (co !== 1'b0) begin bad++; $display("FAIL b2b_co[%0d]: got %b want 0", got, co); end
        $display("b2b: beat %0d s=%0d co=%b cycle=%0d", got, s, co, c);
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (c < 16) begin
        a = WIDTH'(c); b = WIDTH'(2 * c); ci = 1'(c & 1); sub = 1'b0; in_valid = 1'b1;
      end else begin
        drive_idle();
      end
    end
    total++; if (got !== 16) begin bad++; $display("FAIL b2b_count: got %0d want 16", got); end
    total++; if (first !== NSTG) begin bad++; $display("FAIL b2b_first_cycle: got %0d want %0d", first, NSTG); end
    total++; if (last - first !== 15) begin bad++; $display("FAIL b2b_contiguous: got span %0d want 15", last - first); end
  endtask

  task automatic test_stall();
    int sent = 0;
    int got  = 0;
    logic [WIDTH-1:0] exp_s;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      out_ready = !(c >= 10 && c < 15);
      if (sent < 12) begin
        a = WIDTH'(100 + sent); b = WIDTH'(sent); ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end else begin
        drive_idle();
      end
      #1;
      exp_s = WIDTH'(100 + 2 * got);
      if (c >= 10 && c < 15) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[c%0d]: got %b want 1", c, out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[c%0d]: got %b want 0", c, in_ready); end
        total++; if (s !== exp_s) begin bad++; $display("FAIL stall_hold_s[c%0d]: got %h want %h", c, s, exp_s); end
        $display("stall: cycle %0d s=%0d out_valid=%b in_ready=%b", c, s, out_valid, in_ready);
      end
      if (out_valid && out_ready) begin
        total++; if (s !== exp_s) begin bad++; $display("FAIL stall_s[%0d]: got %h want %h", got, s, exp_s); end
        total++; if (co !== 1'b0) begin bad++; $display("FAIL stall_co[%0d]: got %b want 0", got, co); end
        $display("stall: beat %0d s=%0d", got, s);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    out_ready = 1'b1;
    total++; if (got !== 12) begin bad++; $display("FAIL stall_count: got %0d want 12", got); end
    total++; if (sent !== 12) begin bad++; $display("FAIL stall_sent: got %0d want 12", sent); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int lat;
    out_ready = 1'b0;
    @(negedge clk);
    a = 32'd40; b = 32'd2; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      a = WIDTH'(i); b = WIDTH'(i);
    end
    @(negedge clk);
    drive_idle();
    repeat (NSTG - 4) @(negedge clk);
    total++; if (out_valid !== 1'b1 || s !== 32'd42) begin bad++; $display("FAIL rst_mid_pre: got valid=%b s=%h want valid=1 s=0000002a", out_valid, s); end
    // Assert reset between clock edges so that only the asynchronous path
    // can clear the outputs.
    #2 reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    total++; if (s !== 32'h0) begin bad++; $display("FAIL rst_mid_s: got %h want 00000000", s); end
    $display("reset_mid: out_valid=%b s=%h", out_valid, s);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_mid_stale: got %0d results want 0", seen); end
    @(negedge clk);
    a = 32'd1; b = 32'd2; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    drive_idle();
    wait_out(lat);
    total++; if (lat !== NSTG) begin bad++; $display("FAIL rst_mid_new_lat: got %0d want %0d", lat, NSTG); end
    total++; if (s !== 32'd3) begin bad++; $display("FAIL rst_mid_new_s: got %h want 00000003", s); end
    $display("reset_mid: new beat 1+2 s=%0d lat=%0d", s, lat);
    @(negedge clk);
  endtask

`ifdef RCA_PIPE_OVF_EN
  task automatic test_ovf();
    int lat;
    @(negedge clk);
    a = 32'h7FFF_FFFF; b = 32'h0000_0001; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    drive_idle();
    wait_out(lat);
    total++; if (s !== 32'h8000_0000) begin bad++; $display("FAIL ovf_s: got %h want 80000000", s); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    total++; if (co !== 1'b0) begin bad++; $display("FAIL ovf_co: got %b want 0", co); end
    $display("ovf: 7FFFFFFF+1 s=%h ovf=%b co=%b", s, ovf, co);
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_full_ripple();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef RCA_PIPE_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rca_pipe.md
Name: rca_pipe

Overview:
- Parametrised, clocked successor to the team's 32-bit segmented ripple-carry adder.
- Splits a WIDTH-bit add/subtract into WIDTH/SEG ripple segments, one segment resolved per pipeline stage. The carry is registered between stages.
- Uses a valid/ready handshake with backpressure, so it can sit in ALU datapaths clocked faster than a full-width ripple allows.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per stage; NSTG = WIDTH/SEG stages.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat when in_valid & in_ready
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in; ignored when sub=1
- sub  input  1  1 = A - B (B inverted, carry-in forced 1)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result when out_valid & out_ready
- s  output  WIDTH  sum/difference
- co  output  1  carry-out of MSB (for sub: 1 = no borrow)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - all stage valid bits, out_valid, s, co = 0
  - in_ready = 1 after reset deasserts
  - carry and operand pipeline registers = 0
- Global advance: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - When adv=0 every stage register holds.
- Stage 0, on accept:
  - register a, b' = sub ? ~b : b, and c0 = sub ? 1 : ci.
  - then add segment 0 into result bits [SEG-1:0] and register carry c1.
- Stage k (1..NSTG-1):
  - add segment k of the carried operands plus the registered carry ck.
  - write result bits [k*SEG+SEG-1 : k*SEG]; lower bits pass through unchanged.
  - register carry ck+1.
  - Operand bits above the current segment travel with the beat; bits already consumed need not be kept.
- Output register:
  - s, co and out_valid are registered after the last stage.
  - Latency from accept to out_valid = NSTG cycles (WIDTH=32, SEG=4: 8 cycles).
- Throughput: one beat per cycle while out_ready=1. Bubbles (in_valid=0) propagate as valid=0 stages.
- Arithmetic:
  - s = (a + b' + c0) mod 2^WIDTH; co = bit WIDTH of that sum.
  - Wrap-around is silent. No saturation.
- Backpressure:
  - out_valid=1 & out_ready=0 freezes the whole pipe; s and co stay stable.
  - in_ready=0 that cycle; inputs are not sampled.
- Simultaneous events: out_ready=1 while the pipe is full, with in_valid=1 → output retires and a new beat enters in the same edge; no loss, no duplication.
- Reset mid-operation: all in-flight beats are discarded; out_valid drops asynchronously to 0. No result appears for beats accepted before reset.
- Degenerate case SEG=WIDTH: NSTG=1, latency 1.

Optional Feature:
- Macro RCA_PIPE_OVF_EN.
- Defined:
  - adds output port ovf (1 bit), registered alongside s; reset value 0.
  - ovf = signed two's-complement overflow = carry into MSB XOR carry out of MSB, computed in the last stage.
- Undefined: port ovf absent; no extra logic.

Test Plan:
- WIDTH=32, SEG=4, sub=0, a=32'hFFFF_FFFF, b=32'h0000_0001, ci=0 → after 8 cycles s=32'h0, co=1 (full carry ripple across all stages); with OVF_EN, ovf=0.
- sub=1, a=32'd5, b=32'd7 → s=32'hFFFF_FFFE, co=0. Then a=7, b=5 → s=2, co=1.
- Back-to-back beats, out_ready=1, a=i, b=2*i for i=0..15, ci=i[0] → out_valid for 16 consecutive cycles, s=3*i+i[0] in order.
- Stall: out_ready=0 for 5 cycles while full → s, co, out_valid stable; in_ready=0. Release → remaining beats emerge in order, none lost.
- Assert reset mid-stream with 3 beats in flight → out_valid=0 immediately; no stale results after release. First new beat 1+2 → s=3.
- OVF_EN, sub=0, a=32'h7FFF_FFFF, b=1 → s=32'h8000_0000, ovf=1, co=0.
